// File: rtl/mmu_sequencer_if.sv
// Stream, MMU-side and result signals of the 4x4 systolic tile sequencer.
// master = environment (stream source, MMU model, result sink); slave = sequencer.
interface mmu_sequencer_if #(
  parameter int size      = 4,
  parameter int bit_width = 8,
  parameter int acc_width = 32
);
  logic                          start;
  logic                          busy;
  logic                          done;
  logic                          wt_valid;
  logic                          wt_ready;
  logic [bit_width*size-1:0]     wt_row;
  logic                          dat_valid;
  logic                          dat_ready;
  logic [bit_width*size-1:0]     dat_row;
  logic                          mmu_clr;
  logic                          mmu_control;
  logic [bit_width*size-1:0]     mmu_wt_arr;
  logic [bit_width*size-1:0]     mmu_data_arr;
  logic [acc_width*size-1:0]     mmu_acc_out;
  logic                          res_valid;
  logic [$clog2(size)-1:0]       res_idx;
  logic [acc_width*size-1:0]     res_data;

  modport master (
    output start, wt_valid, wt_row, dat_valid, dat_row, mmu_acc_out,
    input  busy, done, wt_ready, dat_ready, mmu_clr, mmu_control,
           mmu_wt_arr, mmu_data_arr, res_valid, res_idx, res_data
  );

  modport slave (
    input  start, wt_valid, wt_row, dat_valid, dat_row, mmu_acc_out,
    output busy, done, wt_ready, dat_ready, mmu_clr, mmu_control,
           mmu_wt_arr, mmu_data_arr, res_valid, res_idx, res_data
  );
endinterface

// File: rtl/mmu_sequencer.sv
// Sequences one systolic MMU tile: buffer weights/data, preload weights,
// stream skewed data rows, wait out the array latency, capture result rows.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// FILL    | accepting size weight rows, then size data rows
// CLR     | one-cycle clear pulse to the array
// WLOAD   | size cycles of weight preload, deepest row first
// STREAM  | 2*size-1 cycles of diagonally skewed data rows
// DRAIN   | res_lat cycles waiting for the first result row
// CAPTURE | size cycles registering mmu_acc_out onto res_data
// DONE    | one-cycle done pulse, last result row still presented
module mmu_sequencer #(
  parameter int size      = 4,
  parameter int bit_width = 8,
  parameter int acc_width = 32,
  parameter int res_lat   = 9
) (
  input logic           clk,
  input logic           reset,
  mmu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, FILL, CLR, WLOAD, STREAM, DRAIN, CAPTURE, DONE
  } state_t;

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam int SPAN  = (res_lat > 2*size) ? res_lat : 2*size;
  localparam int CNT_W = $clog2(SPAN + 1);
  localparam int ROW_W = bit_width*size;

  localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(size - 1);
  localparam logic [CNT_W-1:0] WL_LAST   = CNT_W'(size - 1);
  localparam logic [CNT_W-1:0] ST_LAST   = CNT_W'(2*size - 2);
  localparam logic [CNT_W-1:0] DR_LAST   = CNT_W'(res_lat - 1);
  localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(size - 1);

  state_t           state;
  logic [IDX_W-1:0] fill_idx;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] wbuf [size];
  logic [ROW_W-1:0] dbuf [size];

  // Lane k at stream step t carries data row t-k, so rows enter the array on a diagonal.
  function automatic logic [ROW_W-1:0] skew_row(input logic [CNT_W-1:0] t);
    logic [ROW_W-1:0] r;
    int d;
    r = '0;
    for (int k = 0; k < size; k++) begin
      d = int'(t) - k;
      if (d >= 0 && d < size)
        r[k*bit_width +: bit_width] = dbuf[d[IDX_W-1:0]][k*bit_width +: bit_width];
    end
    return r;
  endfunction

  // Tile buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (reset && state == FILL) begin
      if (bus.wt_valid && bus.wt_ready)
        wbuf[fill_idx] <= bus.wt_row;
      if (bus.dat_valid && bus.dat_ready)
        dbuf[fill_idx] <= bus.dat_row;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      fill_idx         <= '0;
      cnt              <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.wt_ready     <= 1'b0;
      bus.dat_ready    <= 1'b0;
      bus.res_valid    <= 1'b0;
      bus.mmu_control  <= 1'b0;
      bus.mmu_clr      <= 1'b1;
      bus.mmu_wt_arr   <= '0;
      bus.mmu_data_arr <= '0;
      bus.res_data     <= '0;
      bus.res_idx      <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.mmu_clr   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= FILL;
            bus.busy     <= 1'b1;
            bus.wt_ready <= 1'b1;
            fill_idx     <= '0;
            cnt          <= '0;
          end
        end
        FILL: begin
          if (bus.wt_ready && bus.wt_valid) begin
            if (fill_idx == FILL_LAST) begin
              fill_idx      <= '0;
              bus.wt_ready  <= 1'b0;
              bus.dat_ready <= 1'b1;
            end else begin
              fill_idx <= fill_idx + 1'b1;
            end
          end else if (bus.dat_ready && bus.dat_valid) begin
            if (fill_idx == FILL_LAST) begin
              fill_idx      <= '0;
              bus.dat_ready <= 1'b0;
              bus.mmu_clr   <= 1'b1;
              state         <= CLR;
            end else begin
              fill_idx <= fill_idx + 1'b1;
            end
          end
        end
        CLR: begin
          state           <= WLOAD;
          cnt             <= '0;
          bus.mmu_control <= 1'b1;
          bus.mmu_wt_arr  <= wbuf[FILL_LAST];
        end
        WLOAD: begin
          if (cnt == WL_LAST) begin
            state            <= STREAM;
            cnt              <= '0;
            bus.mmu_control  <= 1'b0;
            bus.mmu_wt_arr   <= '0;
            bus.mmu_data_arr <= skew_row('0);
          end else begin
            cnt            <= cnt + 1'b1;
            bus.mmu_wt_arr <= wbuf[IDX_W'(size - 2) - cnt[IDX_W-1:0]];
          end
        end
        STREAM: begin
          if (cnt == ST_LAST) begin
            state            <= DRAIN;
            cnt              <= '0;
            bus.mmu_data_arr <= '0;
          end else begin
            cnt              <= cnt + 1'b1;
            bus.mmu_data_arr <= skew_row(cnt + 1'b1);
          end
        end
        DRAIN: begin
          if (cnt == DR_LAST) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          bus.res_valid <= 1'b1;
          bus.res_data  <= bus.mmu_acc_out;
          bus.res_idx   <= cnt[IDX_W-1:0];
          if (cnt == CP_LAST) begin
            state    <= DONE;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mmu_sequencer.md
Name: mmu_sequencer

Overview:
- Controller that sequences one 4x4 systolic MMU tile operation.
- Buffers a weight tile and a data tile from two valid/ready streams.
- Preloads the weights into the array, then streams the data rows with diagonal skew.
- Waits a fixed pipeline latency, then captures the array's result rows onto a valid-qualified output.

Parameters:
- size, 4, array dimension (rows = columns = lanes)
- bit_width, 8, weight/data element width
- acc_width, 32, accumulator/result element width
- res_lat, 9, cycles from end of STREAM to first valid result row on mmu_acc_out

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- start  in  1  begin one tile operation; sampled only in IDLE
- busy  out  1  high from FILL through CAPTURE
- done  out  1  one-cycle pulse after the last result row
- wt_valid  in  1  weight row valid
- wt_ready  out  1  weight row accepted when wt_valid && wt_ready
- wt_row  in  bit_width*size  weight row; lane k = bits [k*bit_width +: bit_width]
- dat_valid  in  1  data row valid
- dat_ready  out  1  data row accepted when dat_valid && dat_ready
- dat_row  in  bit_width*size  data row, same lane packing as wt_row
- mmu_clr  out  1  active-high clear to the MMU
- mmu_control  out  1  1 = weight load, 0 = compute
- mmu_wt_arr  out  bit_width*size  to the MMU weight input
- mmu_data_arr  out  bit_width*size  to the MMU data input
- mmu_acc_out  in  acc_width*size  MMU result row
- res_valid  out  1  result row valid; no back-pressure
- res_idx  out  $clog2(size)  result row index 0..size-1
- res_data  out  acc_width*size  registered copy of mmu_acc_out

Behaviour:
- Reset (reset==0 at posedge):
  - state = IDLE; all counters = 0.
  - Outputs: busy, done, wt_ready, dat_ready, res_valid, mmu_control = 0; mmu_wt_arr, mmu_data_arr, res_data, res_idx = 0; mmu_clr = 1.
  - Tile buffers are not cleared.
  - Reset mid-operation aborts immediately; no done pulse.
- States: IDLE -> FILL -> CLR -> WLOAD -> STREAM -> DRAIN -> CAPTURE -> DONE -> IDLE. All outputs are registered.
- IDLE: start==1 -> FILL next cycle. start is ignored in every other state.
- FILL:
  - wt_ready=1 until size weight rows are accepted into wbuf[0..size-1], in arrival order.
  - Then dat_ready=1 until size data rows are accepted into dbuf[0..size-1].
  - wt_ready and dat_ready are never high together.
  - Gaps in valid stall FILL without limit.
  - Handshake on the last data row -> CLR.
- CLR: 1 cycle, mmu_clr=1 -> WLOAD.
- WLOAD: size cycles; cycle r drives mmu_control=1 and mmu_wt_arr=wbuf[size-1-r] (deepest row first). Then -> STREAM.
- STREAM:
  - 2*size-1 cycles, mmu_control=0, mmu_wt_arr=0.
  - At cycle t, lane k of mmu_data_arr = dbuf[t-k] lane k if 0<=t-k<size, else 0.
- DRAIN: res_lat cycles, mmu_data_arr=0.
- CAPTURE:
  - size cycles; cycle i registers res_data=mmu_acc_out, res_idx=i, res_valid=1 (visible one cycle later).
  - The last row is therefore presented in the DONE cycle.
- DONE: 1 cycle, done=1, busy=0 -> IDLE.
- busy=1 in FILL, CLR, WLOAD, STREAM, DRAIN and CAPTURE.
- mmu_clr=1 only in CLR and while in reset.
- Cycle count, no stalls, start accepted at cycle 0:
  - FILL 1..8, CLR 9, WLOAD 10..13, STREAM 14..20, DRAIN 21..29, CAPTURE 30..33.
  - res_valid high 31..34; done at 34.
- start held high through DONE starts a new operation from the following IDLE cycle.
- No arithmetic occurs in this block; values pass through unmodified.

Test Plan:
- Basic tile: wbuf = identity (element 1 on diagonal), dbuf rows {1,2,3,4},{5,6,7,8},... -> exact skew pattern on mmu_data_arr (e.g. STREAM t=1 lanes = {5,2,0,0}); mmu_wt_arr order row3..row0 during WLOAD; res_valid cycles 31..34 with res_idx 0..3; done at 34.
- Back-pressure: wt_valid and dat_valid toggled every other cycle -> FILL extends, wt_ready/dat_ready never both high, all later phase lengths unchanged, buffered contents correct.
- Capture fidelity: bench drives mmu_acc_out = cycle counter -> res_data equals the counter value one cycle before each res_valid.
- start while busy: pulse start during STREAM -> ignored; exactly one done pulse and a single operation.
- Reset mid-operation: reset=0 during DRAIN -> next cycle busy=0, res_valid=0, mmu_clr=1; no done pulse; a new start then completes normally.
- Back-to-back: start held high -> second FILL begins the cycle after DONE's IDLE and produces a correct second result set.
